// File: rtl/rank_sort_stream_if.sv
// Window-in / sorted-result-out handshake bundle for rank_sort_stream.
// The slave side is the sorter; the master side is whatever feeds and drains it.
interface rank_sort_stream_if #(
  parameter int DN = 25,
  parameter int DW = 8,
  parameter int IW = (DN > 1) ? $clog2(DN) : 1
);
  // Input window channel
  logic             in_valid;
  logic             in_ready;
  logic             in_descend;
  logic [DW*DN-1:0] in_data;

  // Sorted result channel
  logic             out_valid;
  logic             out_ready;
  logic [DW*DN-1:0] out_data;
  logic [IW*DN-1:0] out_index;
  logic [IW*DN-1:0] out_rank;

  modport slave (
    input  in_valid, in_descend, in_data, out_ready,
    output in_ready, out_valid, out_data, out_index, out_rank
  );

  modport master (
    output in_valid, in_descend, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_index, out_rank
  );
endinterface

// File: rtl/rank_sort_stream.sv
// Parallel rank sorter for one window of DN unsigned DW-bit samples.
// Flow: capture window -> register full comparison matrix -> popcount each
// row into a rank -> scatter samples/indices into sorted lanes -> hold the
// result until downstream takes it. One window is in flight at a time.
module rank_sort_stream #(
  parameter int DN = 25,
  parameter int DW = 8,
  parameter int IW = (DN > 1) ? $clog2(DN) : 1
) (
  input logic            clk,
  input logic            rst,
  rank_sort_stream_if.slave bus
);

  // Largest rank value, used to mirror ascending ranks into descending ones.
  localparam logic [IW-1:0] RANK_MAX = IW'(DN - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CMP  = 3'd1,
    S_RANK = 3'd2,
    S_SCAT = 3'd3,
    S_HOLD = 3'd4
  } state_t;

  state_t state_q, state_d;

  // Captured window and sort direction
  logic [DW-1:0] data_q [DN];
  logic          desc_q;

  // Comparison matrix, row i occupies bits [i*DN +: DN]
  logic [DN*DN-1:0] cmp_q;
  logic [DN*DN-1:0] cmp_d;

  // Per-input rank (already mirrored for descending order)
  logic [IW-1:0] rank_q [DN];
  logic [IW-1:0] rank_d [DN];

  // Result registers
  logic [DW-1:0] odata_q  [DN];
  logic [IW-1:0] oindex_q [DN];
  logic [IW-1:0] orank_q  [DN];
  logic          out_valid_q;

  // State register; reset aborts whatever window is in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: fixed three-cycle pipeline, then wait for the consumer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.in_valid) state_d = S_CMP;
      S_CMP:   state_d = S_RANK;
      S_RANK:  state_d = S_SCAT;
      S_SCAT:  state_d = S_HOLD;
      S_HOLD:  if (bus.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Comparison matrix. Below the diagonal an equal earlier sample counts as
  // "smaller", above it does not; this makes every rank unique and keeps
  // equal values in input order when ascending. The diagonal is always 0.
  generate
    for (genvar gi = 0; gi < DN; gi++) begin : g_cmp_row
      for (genvar gj = 0; gj < DN; gj++) begin : g_cmp_col
        if (gj < gi) begin : g_lower
          assign cmp_d[gi*DN + gj] = (data_q[gi] >= data_q[gj]);
        end else begin : g_upper
          assign cmp_d[gi*DN + gj] = (data_q[gi] > data_q[gj]);
        end
      end
    end
  endgenerate

  // Row popcount gives the ascending rank; it never exceeds DN-1, so IW bits
  // suffice for the running sum.
  generate
    for (genvar gi = 0; gi < DN; gi++) begin : g_rank
      logic [IW-1:0] cnt;

      // Count the set bits of row gi of the comparison matrix.
      always_comb begin
        cnt = '0;
        for (int j = 0; j < DN; j++) begin
          cnt = cnt + IW'(cmp_q[gi*DN + j]);
        end
      end

      assign rank_d[gi] = desc_q ? (RANK_MAX - cnt) : cnt;
    end
  endgenerate

  // Datapath: capture, matrix, rank and scatter registers, one stage per state.
  always_ff @(posedge clk) begin
    if (rst) begin
      desc_q      <= 1'b0;
      cmp_q       <= '0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < DN; i++) begin
        data_q[i]   <= '0;
        rank_q[i]   <= '0;
        odata_q[i]  <= '0;
        oindex_q[i] <= '0;
        orank_q[i]  <= '0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            desc_q <= bus.in_descend;
            for (int i = 0; i < DN; i++) begin
              data_q[i] <= bus.in_data[i*DW +: DW];
            end
          end
        end
        S_CMP: begin
          cmp_q <= cmp_d;
        end
        S_RANK: begin
          for (int i = 0; i < DN; i++) begin
            rank_q[i] <= rank_d[i];
          end
        end
        S_SCAT: begin
          // Ranks form a permutation, so each output lane is written once.
          for (int i = 0; i < DN; i++) begin
            odata_q[rank_q[i]]  <= data_q[i];
            oindex_q[rank_q[i]] <= IW'(i);
            orank_q[i]          <= rank_q[i];
          end
          out_valid_q <= 1'b1;
        end
        S_HOLD: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Flatten result registers onto the lane buses.
  generate
    for (genvar gi = 0; gi < DN; gi++) begin : g_out
      assign bus.out_data[gi*DW +: DW]  = odata_q[gi];
      assign bus.out_index[gi*IW +: IW] = oindex_q[gi];
      assign bus.out_rank[gi*IW +: IW]  = orank_q[gi];
    end
  endgenerate

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_rank_sort_stream.sv
// Bench for rank_sort_stream: a DN=4 instance for directed cases and a
// default DN=25 instance for random windows, checked against a stable
// insertion-sort reference through per-instance expectation queues.
module tb_rank_sort_stream;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rank_sort_stream_if #(.DN(4),  .DW(8)) a_if ();
  rank_sort_stream_if #(.DN(25), .DW(8)) b_if ();

  rank_sort_stream #(.DN(4), .DW(8)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (a_if)
  );

  rank_sort_stream #(.DN(25), .DW(8)) u_dut25 (
    .clk (clk),
    .rst (rst),
    .bus (b_if)
  );

  typedef struct {
    logic [199:0] d;
    logic [124:0] ix;
    logic [124:0] rk;
  } exp_t;

  exp_t q4[$];
  exp_t q25[$];

  int checks = 0;
  int passes = 0;

  int m_d[25];

  // Reference: stable ascending insertion sort; descending is its reversal.
  function automatic exp_t build(input int n, input bit desc);
    int   od[25];
    int   oi[25];
    int   j, tv, ti;
    exp_t e;
    for (int i = 0; i < n; i++) begin
      j = i;
      while (j > 0 && od[j-1] > m_d[i]) begin
        od[j] = od[j-1];
        oi[j] = oi[j-1];
        j--;
      end
      od[j] = m_d[i];
      oi[j] = i;
    end
    if (desc) begin
      for (int p = 0; p < n/2; p++) begin
        tv = od[p]; od[p] = od[n-1-p]; od[n-1-p] = tv;
        ti = oi[p]; oi[p] = oi[n-1-p]; oi[n-1-p] = ti;
      end
    end
    e.d = '0; e.ix = '0; e.rk = '0;
    for (int p = 0; p < n; p++) begin
      e.d[p*8 +: 8] = 8'(od[p]);
      if (n == 4) begin
        e.ix[p*2 +: 2]     = 2'(oi[p]);
        e.rk[oi[p]*2 +: 2] = 2'(p);
      end else begin
        e.ix[p*5 +: 5]     = 5'(oi[p]);
        e.rk[oi[p]*5 +: 5] = 5'(p);
      end
    end
    return e;
  endfunction

  // Offer one window to the DN=4 instance; called and returns at a negedge.
  task automatic drive4(input logic [31:0] data, input bit desc);
    int t = 0;
    while (a_if.in_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (a_if.in_ready !== 1'b1) $display("FAIL drive4_ready: in_ready=%b required 1", a_if.in_ready);
    else passes++;
    a_if.in_valid   = 1'b1;
    a_if.in_data    = data;
    a_if.in_descend = desc;
    for (int i = 0; i < 4; i++) m_d[i] = int'(data[i*8 +: 8]);
    q4.push_back(build(4, desc));
    @(negedge clk);
    a_if.in_valid = 1'b0;
  endtask

  // Wait for a DN=4 result, score it, optionally stall for 'hold' cycles with
  // a stray window offered, then complete the output handshake.
  task automatic collect4(input string nm, input int hold);
    int          t = 0;
    exp_t        e;
    logic [31:0] sd;
    logic [7:0]  si, sr;
    while (a_if.out_valid !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (a_if.out_valid !== 1'b1) $display("FAIL %s timeout: out_valid=%b required 1", nm, a_if.out_valid);
    else passes++;
    checks++;
    if (q4.size() == 0) begin
      $display("FAIL %s scoreboard: queue size 0 required >0", nm);
      return;
    end
    passes++;
    e = q4.pop_front();
    checks++;
    if ({168'd0, a_if.out_data} !== e.d) $display("FAIL %s data: got %h required %h", nm, a_if.out_data, e.d[31:0]);
    else passes++;
    checks++;
    if ({117'd0, a_if.out_index} !== e.ix) $display("FAIL %s index: got %h required %h", nm, a_if.out_index, e.ix[7:0]);
    else passes++;
    checks++;
    if ({117'd0, a_if.out_rank} !== e.rk) $display("FAIL %s rank: got %h required %h", nm, a_if.out_rank, e.rk[7:0]);
    else passes++;
    sd = a_if.out_data; si = a_if.out_index; sr = a_if.out_rank;
    for (int k = 0; k < hold; k++) begin
      a_if.in_valid   = 1'b1;
      a_if.in_data    = $urandom;
      a_if.in_descend = 1'($urandom_range(0, 1));
      @(negedge clk);
      checks++;
      if (a_if.out_valid !== 1'b1 || a_if.in_ready !== 1'b0 || a_if.out_data !== sd ||
          a_if.out_index !== si || a_if.out_rank !== sr)
        $display("FAIL %s hold%0d: valid=%b ready=%b data=%h idx=%h rank=%h required 1 0 %h %h %h",
                 nm, k, a_if.out_valid, a_if.in_ready, a_if.out_data, a_if.out_index, a_if.out_rank, sd, si, sr);
      else passes++;
    end
    a_if.in_valid  = 1'b0;
    a_if.out_ready = 1'b1;
    @(negedge clk);
    a_if.out_ready = 1'b0;
    checks++;
    if (a_if.out_valid !== 1'b0 || a_if.in_ready !== 1'b1)
      $display("FAIL %s release: out_valid=%b in_ready=%b required 0 1", nm, a_if.out_valid, a_if.in_ready);
    else passes++;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (a_if.in_ready !== 1'b1 || a_if.out_valid !== 1'b0)
      $display("FAIL reset4_hs: in_ready=%b out_valid=%b required 1 0", a_if.in_ready, a_if.out_valid);
    else passes++;
    checks++;
    if (a_if.out_data !== '0 || a_if.out_index !== '0 || a_if.out_rank !== '0)
      $display("FAIL reset4_out: data=%h idx=%h rank=%h required 0", a_if.out_data, a_if.out_index, a_if.out_rank);
    else passes++;
    checks++;
    if (b_if.in_ready !== 1'b1 || b_if.out_valid !== 1'b0)
      $display("FAIL reset25_hs: in_ready=%b out_valid=%b required 1 0", b_if.in_ready, b_if.out_valid);
    else passes++;
    checks++;
    if (b_if.out_data !== '0 || b_if.out_index !== '0 || b_if.out_rank !== '0)
      $display("FAIL reset25_out: outputs nonzero required 0");
    else passes++;
  endtask

  task automatic test_ascending();
    int lat = 0;
    drive4({8'd40, 8'd20, 8'd10, 8'd30}, 1'b0);
    while (a_if.out_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != 3) $display("FAIL asc_latency: got %0d edges after accept required 3", lat);
    else passes++;
    collect4("asc", 0);
    checks++;
    if (a_if.out_data !== 32'h281E140A || a_if.out_index !== 8'hC9 || a_if.out_rank !== 8'hD2)
      $display("FAIL asc_const: data=%h idx=%h rank=%h required 281e140a c9 d2", a_if.out_data, a_if.out_index, a_if.out_rank);
    else passes++;
  endtask

  task automatic test_descending();
    drive4({8'd40, 8'd20, 8'd10, 8'd30}, 1'b1);
    collect4("desc", 0);
    checks++;
    if (a_if.out_data !== 32'h0A141E28 || a_if.out_index !== 8'h63 || a_if.out_rank !== 8'h2D)
      $display("FAIL desc_const: data=%h idx=%h rank=%h required 0a141e28 63 2d", a_if.out_data, a_if.out_index, a_if.out_rank);
    else passes++;
  endtask

  task automatic test_ties();
    drive4(32'h05050505, 1'b0);
    collect4("tie_asc", 0);
    checks++;
    if (a_if.out_data !== 32'h05050505 || a_if.out_index !== 8'hE4)
      $display("FAIL tie_asc_const: data=%h idx=%h required 05050505 e4", a_if.out_data, a_if.out_index);
    else passes++;
    drive4(32'h05050505, 1'b1);
    collect4("tie_desc", 0);
    checks++;
    if (a_if.out_data !== 32'h05050505 || a_if.out_index !== 8'h1B)
      $display("FAIL tie_desc_const: data=%h idx=%h required 05050505 1b", a_if.out_data, a_if.out_index);
    else passes++;
  endtask

  task automatic test_backpressure();
    bit seen = 1'b0;
    drive4({8'd7, 8'd200, 8'd0, 8'd99}, 1'b0);
    collect4("bp", 10);
    repeat (6) begin
      @(negedge clk);
      if (a_if.out_valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) $display("FAIL bp_ghost: out_valid=1 after stall required 0");
    else passes++;
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    drive4({8'd9, 8'd8, 8'd7, 8'd6}, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    void'(q4.pop_back());
    checks++;
    if (a_if.in_ready !== 1'b1 || a_if.out_valid !== 1'b0)
      $display("FAIL rstmid_hs: in_ready=%b out_valid=%b required 1 0", a_if.in_ready, a_if.out_valid);
    else passes++;
    checks++;
    if (a_if.out_data !== '0 || a_if.out_index !== '0 || a_if.out_rank !== '0)
      $display("FAIL rstmid_out: data=%h idx=%h rank=%h required 0", a_if.out_data, a_if.out_index, a_if.out_rank);
    else passes++;
    repeat (5) begin
      @(negedge clk);
      if (a_if.out_valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) $display("FAIL rstmid_partial: out_valid=1 after abort required 0");
    else passes++;
    drive4({8'd0, 8'd2, 8'd1, 8'd3}, 1'b0);
    collect4("rstmid_next", 0);
    checks++;
    if (a_if.out_data !== 32'h03020100)
      $display("FAIL rstmid_const: data=%h required 03020100", a_if.out_data);
    else passes++;
  endtask

  task automatic test_random25();
    logic [199:0] dv;
    bit           desc, ok;
    int           mode, v, t, ixp;
    logic [24:0]  seen;
    exp_t         e;
    for (int w = 0; w < 1000; w++) begin
      mode = $urandom_range(0, 2);
      desc = 1'($urandom_range(0, 1));
      for (int i = 0; i < 25; i++) begin
        case (mode)
          0:       v = $urandom_range(0, 255);
          1:       v = ($urandom_range(0, 1) != 0) ? 255 : 0;
          default: v = ($urandom_range(0, 4) == 0) ? 255 : $urandom_range(0, 3);
        endcase
        m_d[i] = v;
        dv[i*8 +: 8] = 8'(v);
      end
      t = 0;
      while (b_if.in_ready !== 1'b1 && t < 50) begin
        @(negedge clk);
        t++;
      end
      checks++;
      if (b_if.in_ready !== 1'b1) $display("FAIL rnd%0d ready: in_ready=%b required 1", w, b_if.in_ready);
      else passes++;
      b_if.in_valid   = 1'b1;
      b_if.in_data    = dv;
      b_if.in_descend = desc;
      q25.push_back(build(25, desc));
      @(negedge clk);
      b_if.in_valid = 1'b0;
      t = 0;
      while (b_if.out_valid !== 1'b1 && t < 50) begin
        @(negedge clk);
        t++;
      end
      e = q25.pop_front();
      checks++;
      if (b_if.out_valid !== 1'b1 || b_if.out_data !== e.d)
        $display("FAIL rnd%0d data: valid=%b got %h required %h", w, b_if.out_valid, b_if.out_data, e.d);
      else passes++;
      checks++;
      if (b_if.out_index !== e.ix) $display("FAIL rnd%0d index: got %h required %h", w, b_if.out_index, e.ix);
      else passes++;
      checks++;
      if (b_if.out_rank !== e.rk) $display("FAIL rnd%0d rank: got %h required %h", w, b_if.out_rank, e.rk);
      else passes++;
      ok = 1'b1;
      seen = '0;
      for (int p = 0; p < 25; p++) begin
        ixp = int'(b_if.out_index[p*5 +: 5]);
        if (ixp >= 25) ok = 1'b0;
        else if (int'(b_if.out_rank[ixp*5 +: 5]) != p) ok = 1'b0;
        v = int'(b_if.out_rank[p*5 +: 5]);
        if (v < 25) seen[v] = 1'b1;
      end
      checks++;
      if (!ok || seen !== {25{1'b1}})
        $display("FAIL rnd%0d perm: inverse_ok=%b rank_cover=%h required 1 1ffffff", w, ok, seen);
      else passes++;
      t = 0;
      do begin
        b_if.out_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        t++;
      end while (b_if.out_valid === 1'b1 && t < 200);
      b_if.out_ready = 1'b0;
      checks++;
      if (b_if.out_valid !== 1'b0) $display("FAIL rnd%0d release: out_valid=%b required 0", w, b_if.out_valid);
      else passes++;
    end
  endtask

  initial begin
    a_if.in_valid = 1'b0; a_if.in_data = '0; a_if.in_descend = 1'b0; a_if.out_ready = 1'b0;
    b_if.in_valid = 1'b0; b_if.in_data = '0; b_if.in_descend = 1'b0; b_if.out_ready = 1'b0;
    test_reset();
    test_ascending();
    test_descending();
    test_ties();
    test_backpressure();
    test_reset_mid();
    test_random25();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passes, checks);
    $fatal(1, "watchdog");
  end

endmodule
